// File: rtl/pcs_host_bridge_if.sv
// pcs_host_bridge_if: host byte streams plus PCS controller user-bus signals.
// Signals:
//   host_tx_valid/host_tx_data/host_tx_ready : host TX stream (host -> bridge)
//   host_rx_valid/host_rx_data/host_rx_ready : host RX stream (bridge -> host)
//   bus_in, bus_out, bus_oe                  : shared 8-bit bus (resolved in, driven out, enable)
//   rx_req, rx_ack                           : RX burst request / grant
//   occupied, rx_avail, rx_valid             : controller status and RX byte strobe
// Modports: slave = bridge side, master = host/controller side.
interface pcs_host_bridge_if;
    logic       host_tx_valid;
    logic [7:0] host_tx_data;
    logic       host_tx_ready;
    logic       host_rx_valid;
    logic [7:0] host_rx_data;
    logic       host_rx_ready;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       rx_req;
    logic       rx_ack;
    logic       occupied;
    logic       rx_avail;
    logic       rx_valid;
    modport slave (
        input  host_tx_valid, host_tx_data, host_rx_ready, bus_in, rx_ack, occupied, rx_avail, rx_valid,
        output host_tx_ready, host_rx_valid, host_rx_data, bus_out, bus_oe, rx_req
    );
    modport master (
        output host_tx_valid, host_tx_data, host_rx_ready, bus_in, rx_ack, occupied, rx_avail, rx_valid,
        input  host_tx_ready, host_rx_valid, host_rx_data, bus_out, bus_oe, rx_req
    );
endinterface

// File: rtl/pcs_host_bridge.sv
// pcs_host_bridge: host TX/RX byte streams to the PCS controller half-duplex user bus.
// Ports:
//   i_clk_sys        : system clock
//   i_rst            : asynchronous active-high reset
//   bif (slave)      : host streams and controller bus signals
//   o_tx_byte_cnt    : TX pop count    (only with PCS_BRIDGE_STATS_EN)
//   o_rx_byte_cnt    : RX push count   (only with PCS_BRIDGE_STATS_EN)
// Optional feature macro: PCS_BRIDGE_STATS_EN (statistics counters).
module pcs_host_bridge #(
    parameter int TX_DEPTH  = 4,
    parameter int RX_DEPTH  = 4,
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk_sys,
    input  logic             i_rst,
    pcs_host_bridge_if.slave bif
`ifdef PCS_BRIDGE_STATS_EN
    ,
    output logic [CNT_W-1:0] o_tx_byte_cnt,
    output logic [CNT_W-1:0] o_rx_byte_cnt
);
`else
);
`endif
    localparam int TA = $clog2(TX_DEPTH);
    localparam int RA = $clog2(RX_DEPTH);
    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic [2:0] {IDLE, RX_REQ, RX_XFER, TX, TURN} state_t;
    state_t r_state, w_state_nxt;

    logic [7:0]    r_tx_mem [TX_DEPTH];
    logic [7:0]    r_rx_mem [RX_DEPTH];
    logic [TA:0]   r_tx_wp, r_tx_rp, w_tx_wp_nxt, w_tx_rp_nxt;
    logic [RA:0]   r_rx_wp, r_rx_rp, w_rx_used;
    logic [BW-1:0] r_bcnt, w_bcnt_nxt;
    logic [7:0]    r_bus_out, w_tx_head_nxt;
    logic          r_bus_oe, r_rx_req;
    logic          w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
    logic          w_rx_push, w_rx_pop, w_rx_empty, w_rx_full, w_rx_room, w_burst_end;

    assign w_tx_empty  = r_tx_wp == r_tx_rp;
    assign w_tx_full   = r_tx_wp == {~r_tx_rp[TA], r_tx_rp[TA-1:0]};
    assign w_tx_push   = bif.host_tx_valid && !w_tx_full;
    assign w_tx_pop    = r_state == TX && !bif.occupied;
    assign w_tx_wp_nxt = r_tx_wp + (TA+1)'(w_tx_push);
    assign w_tx_rp_nxt = r_tx_rp + (TA+1)'(w_tx_pop);
    // Next head for the registered bus byte; bypass when that slot is being written this cycle.
    assign w_tx_head_nxt = (w_tx_push && r_tx_wp == w_tx_rp_nxt) ? bif.host_tx_data
                                                                  : r_tx_mem[w_tx_rp_nxt[TA-1:0]];

    assign w_rx_empty = r_rx_wp == r_rx_rp;
    assign w_rx_full  = r_rx_wp == {~r_rx_rp[RA], r_rx_rp[RA-1:0]};
    assign w_rx_push  = r_state == RX_XFER && bif.rx_valid;
    assign w_rx_pop   = !w_rx_empty && bif.host_rx_ready;
    assign w_rx_used  = r_rx_wp - r_rx_rp;
    // A burst may only start when a full burst is guaranteed to fit.
    assign w_rx_room  = (RX_DEPTH - int'(w_rx_used)) >= BURST_MAX;

    assign w_bcnt_nxt  = r_bcnt + BW'(w_tx_pop || w_rx_push);
    assign w_burst_end = int'(w_bcnt_nxt) >= BURST_MAX;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = (bif.rx_avail && w_rx_room) ? RX_REQ :
                                   (!w_tx_empty && !bif.occupied) ? TX : IDLE;
            RX_REQ:  w_state_nxt = bif.rx_ack ? RX_XFER : RX_REQ;
            RX_XFER: w_state_nxt = (w_burst_end || !bif.rx_avail || !bif.rx_ack) ? TURN : RX_XFER;
            TX:      w_state_nxt = ((w_tx_pop && w_tx_rp_nxt == w_tx_wp_nxt) || w_burst_end || bif.rx_avail)
                                   ? TURN : TX;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_tx_wp   <= '0;
            r_tx_rp   <= '0;
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_bcnt    <= '0;
            r_bus_oe  <= 1'b0;
            r_rx_req  <= 1'b0;
            r_bus_out <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tx_wp  <= w_tx_wp_nxt;
            r_tx_rp  <= w_tx_rp_nxt;
            r_rx_wp  <= r_rx_wp + (RA+1)'(w_rx_push);
            r_rx_rp  <= r_rx_rp + (RA+1)'(w_rx_pop);
            // Any state change starts a fresh ownership period.
            r_bcnt   <= (w_state_nxt != r_state) ? '0 : w_bcnt_nxt;
            r_bus_oe <= w_state_nxt == TX;
            r_rx_req <= w_state_nxt == RX_REQ || w_state_nxt == RX_XFER;
            if (w_state_nxt == TX)
                r_bus_out <= w_tx_head_nxt;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wp[TA-1:0]] <= bif.host_tx_data;
        if (w_rx_push)
            r_rx_mem[r_rx_wp[RA-1:0]] <= bif.bus_in;
    end

    always_ff @(posedge i_clk_sys)
        if (!i_rst && w_rx_push)
            assert (!w_rx_full);

`ifdef PCS_BRIDGE_STATS_EN
    logic [CNT_W-1:0] r_tx_cnt, r_rx_cnt;
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(w_tx_pop);
            r_rx_cnt <= r_rx_cnt + CNT_W'(w_rx_push);
        end
    end
    assign o_tx_byte_cnt = r_tx_cnt;
    assign o_rx_byte_cnt = r_rx_cnt;
`endif

    assign bif.host_tx_ready = !w_tx_full;
    assign bif.host_rx_valid = !w_rx_empty;
    assign bif.host_rx_data  = r_rx_mem[r_rx_rp[RA-1:0]];
    assign bif.bus_out       = r_bus_out;
    assign bif.bus_oe        = r_bus_oe;
    assign bif.rx_req        = r_rx_req;
endmodule

// File: tb/tb_pcs_host_bridge.sv
// tb_pcs_host_bridge: directed self-checking bench for pcs_host_bridge.
module tb_pcs_host_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;
    int   clash = 0;
    logic prev_oe = 1'b0;
    logic [7:0] got_q[$];

    pcs_host_bridge_if bif();
`ifdef PCS_BRIDGE_STATS_EN
    logic [15:0] tx_cnt, rx_cnt;
`endif

    pcs_host_bridge dut (
        .i_clk_sys(clk),
        .i_rst(rst),
        .bif(bif)
`ifdef PCS_BRIDGE_STATS_EN
        ,
        .o_tx_byte_cnt(tx_cnt),
        .o_rx_byte_cnt(rx_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bif.rx_req && (bif.bus_oe || prev_oe))
            clash++;
        prev_oe = bif.bus_oe;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic get_tx(input int n, output int bursts);
        logic prev;
        prev = 1'b0;
        bursts = 0;
        got_q = {};
        for (int c = 0; c < 40 && got_q.size() < n; c++) begin
            if (bif.bus_oe && !prev)
                bursts++;
            prev = bif.bus_oe;
            if (bif.bus_oe && !bif.occupied)
                got_q.push_back(bif.bus_out);
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        int   bursts, idx;
        logic acc, prev;
        bif.host_tx_valid = 0;
        bif.host_tx_data  = 0;
        bif.host_rx_ready = 0;
        bif.bus_in        = 0;
        bif.rx_ack        = 0;
        bif.occupied      = 0;
        bif.rx_avail      = 0;
        bif.rx_valid      = 0;
        step(2);
        chk("rst_oe", bif.bus_oe, 0);
        chk("rst_req", bif.rx_req, 0);
        chk("rst_out", bif.bus_out, 0);
        chk("rst_hrv", bif.host_rx_valid, 0);
        chk("rst_htr", bif.host_tx_ready, 1);
        rst = 0;

        bif.host_tx_valid = 1;
        bif.host_tx_data  = 8'h11;
        step();
        chk("t1_oe0", bif.bus_oe, 0);
        bif.host_tx_data = 8'h22;
        step();
        chk("t1_oe1", bif.bus_oe, 1);
        chk("t1_b11", bif.bus_out, 8'h11);
        bif.host_tx_data = 8'h33;
        step();
        chk("t1_b22", bif.bus_out, 8'h22);
        bif.host_tx_valid = 0;
        step();
        chk("t1_b33", bif.bus_out, 8'h33);
        chk("t1_oe2", bif.bus_oe, 1);
        step();
        chk("t1_turn", bif.bus_oe, 0);
        step();
        chk("t1_idle", bif.bus_oe | bif.rx_req, 0);

        bif.occupied = 1;
        for (int i = 0; i < 4; i++) begin
            bif.host_tx_valid = 1;
            bif.host_tx_data  = 8'(8'h41 + i);
            step();
        end
        chk("t2_full", bif.host_tx_ready, 0);
        chk("t2_hold", bif.bus_oe, 0);
        idx = 4;
        bif.host_tx_data = 8'h45;
        bif.occupied = 0;
        got_q = {};
        bursts = 0;
        prev = 0;
        for (int c = 0; c < 40 && got_q.size() < 6; c++) begin
            acc = bif.host_tx_valid && bif.host_tx_ready;
            if (bif.bus_oe && !prev)
                bursts++;
            prev = bif.bus_oe;
            if (bif.bus_oe)
                got_q.push_back(bif.bus_out);
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                bif.host_tx_valid = idx < 6;
                bif.host_tx_data  = 8'(8'h41 + idx);
            end
            @(negedge clk);
        end
        chk("t2_cnt", got_q.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("t2_byte", got_q[i], 8'(8'h41 + i));
        chk("t2_bursts", bursts, 2);
        step(2);

        bif.rx_avail = 1;
        step();
        chk("t3_req", bif.rx_req, 1);
        chk("t3_oe", bif.bus_oe, 0);
        step(2);
        chk("t3_wait", bif.rx_req, 1);
        bif.rx_ack = 1;
        step();
        for (int k = 0; k < 4; k++) begin
            bif.rx_valid = 1;
            bif.bus_in   = 8'(8'hA0 + k);
            step();
            chk("t3_hrv", bif.host_rx_valid, 1);
            chk("t3_reqk", bif.rx_req, k < 3);
        end
        bif.rx_valid = 0;
        bif.rx_ack   = 0;
        bif.rx_avail = 0;
        bif.host_rx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_rd", bif.host_rx_data, 8'(8'hA0 + i));
            step();
        end
        bif.host_rx_ready = 0;
        chk("t3_empty", bif.host_rx_valid, 0);

        bif.occupied = 1;
        for (int i = 0; i < 3; i++) begin
            bif.host_tx_valid = 1;
            bif.host_tx_data  = 8'(8'h51 + i);
            step();
        end
        bif.host_tx_valid = 0;
        bif.occupied = 0;
        step();
        chk("t4_oe", bif.bus_oe, 1);
        chk("t4_b51", bif.bus_out, 8'h51);
        bif.rx_avail = 1;
        step();
        chk("t4_turn", {bif.bus_oe, bif.rx_req}, 0);
        step();
        chk("t4_idle", bif.rx_req, 0);
        step();
        chk("t4_req", bif.rx_req, 1);
        bif.rx_ack = 1;
        step();
        bif.rx_valid = 1;
        bif.bus_in   = 8'hB0;
        bif.rx_avail = 0;
        step();
        bif.rx_valid = 0;
        bif.rx_ack   = 0;
        chk("t4_reqdn", bif.rx_req, 0);
        chk("t4_rxd", bif.host_rx_data, 8'hB0);
        get_tx(2, bursts);
        chk("t4_cnt", got_q.size(), 2);
        chk("t4_b52", got_q[0], 8'h52);
        chk("t4_b53", got_q[1], 8'h53);
        chk("t4_bursts", bursts, 1);

        bif.rx_avail = 1;
        step(3);
        chk("t5_noreq", bif.rx_req, 0);
        bif.host_rx_ready = 1;
        step();
        bif.host_rx_ready = 0;
        chk("t5_drain", bif.host_rx_valid, 0);
        step();
        chk("t5_req", bif.rx_req, 1);

        bif.rx_ack = 1;
        step();
        bif.rx_valid = 1;
        bif.bus_in   = 8'hC0;
        step();
        bif.rx_valid = 0;
        chk("t6_xfer", bif.rx_req, 1);
        chk("t6_hrv", bif.host_rx_valid, 1);
`ifdef PCS_BRIDGE_STATS_EN
        chk("t6_txcnt", tx_cnt, 12);
        chk("t6_rxcnt", rx_cnt, 6);
`endif
        #2 rst = 1;
        #1;
        chk("t6_req0", bif.rx_req, 0);
        chk("t6_hrv0", bif.host_rx_valid, 0);
        chk("t6_oe0", bif.bus_oe, 0);
`ifdef PCS_BRIDGE_STATS_EN
        chk("t6_txcnt0", tx_cnt, 0);
        chk("t6_rxcnt0", rx_cnt, 0);
`endif
        bif.rx_ack   = 0;
        bif.rx_avail = 0;
        step();
        rst = 0;
        step(2);
        chk("t6_after", {bif.host_tx_ready, bif.rx_req, bif.bus_oe}, 3'b100);
        chk("no_clash", clash, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
